// File: rtl/inst_mem_loader.sv
// Framed byte-stream loader for the rvseed instruction memory.
// Packs little-endian words, writes them sequentially, then releases core reset on a good checksum.
module inst_mem_loader #(
  parameter int         CPU_WIDTH = 32,
  parameter int         IM_ADDR_W = 8,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [7:0]           s_data,
  input  logic                 reload,
  output logic                 im_we,
  output logic [IM_ADDR_W-1:0] im_addr,
  output logic [CPU_WIDTH-1:0] im_wdata,
  output logic                 core_rst_n,
  output logic                 load_done,
  output logic                 load_err
);

  localparam int DEPTH = 1 << IM_ADDR_W;

  typedef enum logic [2:0] {
    ST_SYNC, ST_CNT0, ST_CNT1, ST_DATA, ST_CSUM, ST_RUN, ST_ERR
  } state_t;

  state_t               state, next_state;
  logic                 accept;
  logic [7:0]           cnt_lo;
  logic [15:0]          cnt_full;
  logic [1:0]           byte_idx;
  logic [IM_ADDR_W-1:0] word_addr;
  logic [IM_ADDR_W-1:0] last_addr;
  logic [CPU_WIDTH-9:0] word_buf;
  logic [7:0]           csum;

  assign cnt_full = {s_data, cnt_lo};
  assign accept   = s_valid & s_ready;

  // Ready is held low while in reset and during any reload cycle.
  always_comb begin
    s_ready = 1'b0;
    case (state)
      ST_SYNC, ST_CNT0, ST_CNT1, ST_DATA, ST_CSUM: s_ready = rst_n & ~reload;
      default:                                    s_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_SYNC;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (reload) begin
      next_state = ST_SYNC;
    end else if (accept) begin
      case (state)
        ST_SYNC: if (s_data == SYNC_BYTE) next_state = ST_CNT0;
        ST_CNT0: next_state = ST_CNT1;
        ST_CNT1: begin
          if (cnt_full == 16'd0)                  next_state = ST_CSUM;
          else if ({1'b0, cnt_full} > 17'(DEPTH)) next_state = ST_ERR;
          else                                    next_state = ST_DATA;
        end
        ST_DATA: if (byte_idx == 2'd3 && word_addr == last_addr) next_state = ST_CSUM;
        ST_CSUM: next_state = (s_data == csum) ? ST_RUN : ST_ERR;
        default: next_state = state;
      endcase
    end
  end

  // Word assembly and the registered write strobe; last_addr is N-1 so the address never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_lo    <= '0;
      byte_idx  <= '0;
      word_addr <= '0;
      last_addr <= '0;
      word_buf  <= '0;
      csum      <= '0;
      im_we     <= 1'b0;
      im_addr   <= '0;
      im_wdata  <= '0;
    end else begin
      im_we <= 1'b0;
      if (reload) begin
        byte_idx  <= '0;
        word_addr <= '0;
        csum      <= '0;
      end else if (accept) begin
        case (state)
          ST_CNT0: cnt_lo <= s_data;
          ST_CNT1: begin
            last_addr <= IM_ADDR_W'(cnt_full - 16'd1);
            word_addr <= '0;
            byte_idx  <= '0;
            csum      <= '0;
          end
          ST_DATA: begin
            csum     <= csum ^ s_data;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_buf[7:0]   <= s_data;
              2'd1: word_buf[15:8]  <= s_data;
              2'd2: word_buf[23:16] <= s_data;
              default: begin
                im_we    <= 1'b1;
                im_addr  <= word_addr;
                im_wdata <= {s_data, word_buf};
                if (word_addr != last_addr) word_addr <= word_addr + 1'b1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rst_n <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      core_rst_n <= (next_state == ST_RUN);
      load_done  <= (next_state == ST_RUN);
      load_err   <= (next_state == ST_ERR);
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed self-checking bench for inst_mem_loader: good/bad frames, garbage, limits, reload and reset.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        reload;
  logic        im_we;
  logic [7:0]  im_addr;
  logic [31:0] im_wdata;
  logic        core_rst_n;
  logic        load_done;
  logic        load_err;

  int          checks = 0;
  int          errors = 0;
  int          wr_count = 0;
  bit          jitter = 1'b0;
  logic [31:0] tb_mem [0:255];

  inst_mem_loader #(.CPU_WIDTH(32), .IM_ADDR_W(8), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .reload(reload), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .core_rst_n(core_rst_n), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && im_we) begin
      tb_mem[im_addr] <= im_wdata;
      wr_count++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Presents one byte, optionally after random idle cycles, and returns #1 after it is taken.
  task automatic applyStimulus(input logic [7:0] b);
    int waited;
    @(negedge clk);
    if (jitter) begin
      repeat ($urandom_range(0, 2)) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
    end
    s_valid = 1'b1;
    s_data  = b;
    waited  = 0;
    while (!s_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: byte 0x%02h never accepted, s_ready=%0b required 1", b, s_ready);
      s_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      s_valid = 1'b0;
    end
  endtask

  task automatic sendWord(input logic [31:0] w);
    applyStimulus(w[7:0]);
    applyStimulus(w[15:8]);
    applyStimulus(w[23:16]);
    applyStimulus(w[31:24]);
  endtask

  task automatic sendHeader(input logic [15:0] n);
    applyStimulus(8'hA5);
    applyStimulus(n[7:0]);
    applyStimulus(n[15:8]);
  endtask

  // A byte is offered alongside the reload pulse and must not be taken.
  task automatic pulseReload();
    @(negedge clk);
    reload  = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'hA5;
    #1;
    checkOutput("reload_blocks_ready", 32'(s_ready), 32'd0);
    @(posedge clk);
    #1;
    reload  = 1'b0;
    s_valid = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    reload  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_s_ready",    32'(s_ready),    32'd0);
    checkOutput("rst_im_we",      32'(im_we),      32'd0);
    checkOutput("rst_im_addr",    32'(im_addr),    32'd0);
    checkOutput("rst_im_wdata",   im_wdata,        32'd0);
    checkOutput("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    checkOutput("rst_load_done",  32'(load_done),  32'd0);
    checkOutput("rst_load_err",   32'(load_err),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("sync_s_ready", 32'(s_ready), 32'd1);

    // Two-word frame; XOR of 13 00 00 00 93 00 10 00 is 0x90.
    $display("[TB] good two-word frame");
    sendHeader(16'd2);
    sendWord(32'h00000013);
    checkOutput("w0_im_we",   32'(im_we),   32'd1);
    checkOutput("w0_im_addr", 32'(im_addr), 32'd0);
    checkOutput("w0_wdata",   im_wdata,     32'h00000013);
    applyStimulus(8'h93);
    checkOutput("w1_b0_no_we", 32'(im_we), 32'd0);
    applyStimulus(8'h00);
    applyStimulus(8'h10);
    applyStimulus(8'h00);
    checkOutput("w1_im_we",   32'(im_we),   32'd1);
    checkOutput("w1_im_addr", 32'(im_addr), 32'd1);
    checkOutput("w1_wdata",   im_wdata,     32'h00100093);
    checkOutput("pre_csum_core_rst_n", 32'(core_rst_n), 32'd0);
    applyStimulus(8'h90);
    checkOutput("run_core_rst_n", 32'(core_rst_n), 32'd1);
    checkOutput("run_load_done",  32'(load_done),  32'd1);
    checkOutput("run_load_err",   32'(load_err),   32'd0);
    checkOutput("run_s_ready",    32'(s_ready),    32'd0);
    checkOutput("a_wr_count",     32'(wr_count),   32'd2);

    pulseReload();
    checkOutput("reload_core_rst_n", 32'(core_rst_n), 32'd0);
    checkOutput("reload_load_done",  32'(load_done),  32'd0);
    checkOutput("reload_s_ready",    32'(s_ready),    32'd1);

    $display("[TB] bad checksum frame");
    sendHeader(16'd2);
    sendWord(32'h00000013);
    sendWord(32'h00100093);
    applyStimulus(8'h91);
    checkOutput("bad_load_err",   32'(load_err),   32'd1);
    checkOutput("bad_core_rst_n", 32'(core_rst_n), 32'd0);
    checkOutput("bad_load_done",  32'(load_done),  32'd0);
    checkOutput("bad_s_ready",    32'(s_ready),    32'd0);
    checkOutput("bad_wr_count",   32'(wr_count),   32'd4);

    pulseReload();
    checkOutput("reload_err_clear", 32'(load_err), 32'd0);

    // Garbage then a one-word frame; DE^AD^BE^EF = 0x22.
    $display("[TB] leading garbage");
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    applyStimulus(8'h5A);
    sendHeader(16'd1);
    sendWord(32'hEFBEADDE);
    applyStimulus(8'h22);
    checkOutput("garb_load_done", 32'(load_done), 32'd1);
    checkOutput("garb_wr_count",  32'(wr_count),  32'd5);
    checkOutput("garb_mem0",      tb_mem[0],      32'hEFBEADDE);

    pulseReload();
    $display("[TB] oversize count");
    sendHeader(16'h0101);
    checkOutput("big_load_err",  32'(load_err), 32'd1);
    checkOutput("big_s_ready",   32'(s_ready),  32'd0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("big_wr_count",  32'(wr_count), 32'd5);

    pulseReload();
    $display("[TB] zero-length frame");
    sendHeader(16'd0);
    applyStimulus(8'h00);
    checkOutput("zero_load_done", 32'(load_done), 32'd1);
    checkOutput("zero_wr_count",  32'(wr_count),  32'd5);
    pulseReload();
    checkOutput("zero_rl_core_rst_n", 32'(core_rst_n), 32'd0);
    checkOutput("zero_rl_load_done",  32'(load_done),  32'd0);
    checkOutput("zero_rl_s_ready",    32'(s_ready),    32'd1);

    // Aborted frame mid-word, then a clean resend; second frame XOR is 0x01.
    $display("[TB] reload mid-word with jittered valid");
    jitter = 1'b1;
    sendHeader(16'd3);
    sendWord(32'h11111111);
    sendWord(32'h22222222);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    pulseReload();
    sendHeader(16'd3);
    sendWord(32'h12345678);
    sendWord(32'h9ABCDEF0);
    sendWord(32'h00000001);
    applyStimulus(8'h01);
    jitter = 1'b0;
    checkOutput("jit_load_done", 32'(load_done), 32'd1);
    checkOutput("jit_wr_count",  32'(wr_count),  32'd10);
    checkOutput("jit_mem0",      tb_mem[0],      32'h12345678);
    checkOutput("jit_mem1",      tb_mem[1],      32'h9ABCDEF0);
    checkOutput("jit_mem2",      tb_mem[2],      32'h00000001);

    $display("[TB] async reset while running");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_core_rst_n", 32'(core_rst_n), 32'd0);
    checkOutput("arst_load_done",  32'(load_done),  32'd0);
    checkOutput("arst_s_ready",    32'(s_ready),    32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
